// File: rtl/arm_pkg.sv
// Shared types and geometry helpers for the MEM-stage data cache.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Geometry of the default configuration (32-bit address/data, 64 sets).
  localparam int INDEX_W  = clog2(64);
  localparam int OFFSET_W = clog2(32 / 8);
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;

endpackage

// File: rtl/mem_cache_ctrl_way_array.sv
// One cache way: per-set valid/tag/data, synchronous write, asynchronous read.
module cache_way_array #(
  parameter int SETS    = 64,
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 24,
  parameter int DATA_W  = 32
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               clear,
  input  logic               we,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [DATA_W-1:0]  wdata,
  output logic               valid,
  output logic [TAG_W-1:0]   tag,
  output logic [DATA_W-1:0]  data
);

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS];

  // Valid bits: cleared by reset and flush, set by any line write.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) valid_q <= '0;
    else if (clear) valid_q <= '0;
    else if (we) valid_q[index] <= 1'b1;
  end

  // Tag/data storage needs no reset; it is qualified by valid.
  always_ff @(posedge clock) begin
    if (we) begin
      tag_q[index]  <= wtag;
      data_q[index] <= wdata;
    end
  end

  assign valid = valid_q[index];
  assign tag   = tag_q[index];
  assign data  = data_q[index];

endmodule

// File: rtl/mem_cache_ctrl.sv
// 2-way set-associative write-through / no-write-allocate data cache.
//   state   | meaning
//   IDLE    | serve read hits, issue misses and write-throughs, apply flush
//   RD_MISS | wait for mem_ack, then fill the victim way
//   WR_THRU | wait for mem_ack of the write-through
module mem_cache_ctrl
  import arm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(1024),
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int OFF_BITS = clog2(DATA_W / 8);
  localparam int IDX_BITS = clog2(SETS);
  localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(DATA_W / 8 - 1));

  state_t state, state_nx;

  logic [ADDR_W-1:0]   off, off_aligned;
  logic [IDX_BITS-1:0] index;
  logic [TAG_BITS-1:0] tag;
  logic                req, flush_eff, flush_pend;
  logic [SETS-1:0]     lru;

  logic                v0, v1, hit0, hit1, victim;
  logic [TAG_BITS-1:0] t0, t1;
  logic [DATA_W-1:0]   d0, d1, way_wdata;

  logic we0, we1, clear_all, lru_we, lru_val;
  logic hit_inc, miss_inc, issue_rd, issue_wr, done, pend_set, pend_clr;

  assign off         = addr - BASE_ADDR;
  assign off_aligned = off & ALIGN_MASK;
  assign index       = off[OFF_BITS +: IDX_BITS];
  assign tag         = off[OFF_BITS + IDX_BITS +: TAG_BITS];
  assign req         = rd_en | wr_en;
  assign flush_eff   = flush | flush_pend;

  cache_way_array #(.SETS(SETS), .INDEX_W(IDX_BITS), .TAG_W(TAG_BITS), .DATA_W(DATA_W)) u_way0 (
    .clock(clock), .rst(rst), .clear(clear_all), .we(we0), .index(index),
    .wtag(tag), .wdata(way_wdata), .valid(v0), .tag(t0), .data(d0)
  );

  cache_way_array #(.SETS(SETS), .INDEX_W(IDX_BITS), .TAG_W(TAG_BITS), .DATA_W(DATA_W)) u_way1 (
    .clock(clock), .rst(rst), .clear(clear_all), .we(we1), .index(index),
    .wtag(tag), .wdata(way_wdata), .valid(v1), .tag(t1), .data(d1)
  );

  assign hit0   = v0 && (t0 == tag);
  assign hit1   = v1 && (t1 == tag);
  // Prefer an empty way; otherwise evict the least-recently-used one.
  assign victim = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru[index]);
  assign way_wdata = (state == RD_MISS) ? mem_rdata : wdata;

  // Next state, ready/rdata and array/counter control strobes.
  always_comb begin
    state_nx  = state;
    ready     = 1'b1;
    rdata     = '0;
    we0       = 1'b0;
    we1       = 1'b0;
    clear_all = 1'b0;
    lru_we    = 1'b0;
    lru_val   = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    issue_rd  = 1'b0;
    issue_wr  = 1'b0;
    done      = 1'b0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (flush_eff) begin
          // Flush wins; any request is retried next cycle against empty arrays.
          clear_all = 1'b1;
          pend_clr  = 1'b1;
          ready     = !req;
        end else if (wr_en) begin
          ready    = 1'b0;
          issue_wr = 1'b1;
          state_nx = WR_THRU;
          we0      = hit0;
          we1      = hit1;
          lru_we   = hit0 | hit1;
          lru_val  = hit0;
        end else if (rd_en) begin
          if (hit0 || hit1) begin
            rdata   = hit0 ? d0 : d1;
            lru_we  = 1'b1;
            lru_val = hit0;
            hit_inc = 1'b1;
          end else begin
            ready    = 1'b0;
            miss_inc = 1'b1;
            issue_rd = 1'b1;
            state_nx = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        ready    = 1'b0;
        pend_set = flush;
        if (mem_ack) begin
          ready    = 1'b1;
          rdata    = mem_rdata;
          we0      = !victim;
          we1      = victim;
          lru_we   = 1'b1;
          lru_val  = !victim;
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      WR_THRU: begin
        ready    = 1'b0;
        pend_set = flush;
        if (mem_ack) begin
          ready    = 1'b1;
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, memory-side request registers, LRU bits, pending flush, counters.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      lru        <= '0;
      flush_pend <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (issue_rd || issue_wr) begin
        mem_req  <= 1'b1;
        mem_we   <= issue_wr;
        mem_addr <= off_aligned;
      end else if (done) begin
        mem_req <= 1'b0;
      end
      if (issue_wr) mem_wdata <= wdata;
      if (clear_all) lru <= '0;
      else if (lru_we) lru[index] <= lru_val;
      if (pend_set) flush_pend <= 1'b1;
      else if (pend_clr) flush_pend <= 1'b0;
      if (hit_inc && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
      if (miss_inc && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: doc/mem_cache_ctrl.md
Name: mem_cache_ctrl

Overview:
- Parametrised, 2-way set-associative, write-through / no-write-allocate data cache between the MEM stage and a slow backing memory with a req/ack handshake.
- Replaces the fixed single-cycle data memory path: it subtracts a configurable base address and drives a ready output.
- The pipeline ORs ~ready into its global freeze, the same way the multi-cycle exp unit's ready is used.
- Also provides cache flush and hit/miss statistics counters.

Parameters:
- ADDR_W, 32, byte-address width from the ALU result.
- DATA_W, 32, word width. Must be a multiple of 8.
- SETS, 64, number of sets. Must be a power of 2, at least 2.
- BASE_ADDR, 1024, subtracted from addr before indexing. The backing memory sees the offset address.
- CNT_W, 32, width of the statistics counters.

Ports:
- clock  in  1  system clock
- rst  in  1  reset
- rd_en  in  1  load request from MEM stage
- wr_en  in  1  store request from MEM stage
- addr  in  ADDR_W  byte address (ALU result)
- wdata  in  DATA_W  store data (Rm value)
- flush  in  1  invalidate all lines
- rdata  out  DATA_W  load result
- ready  out  1  0 means the pipeline must freeze
- mem_req  out  1  backing memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  offset word-aligned address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  single-cycle completion pulse
- hit_cnt  out  CNT_W  read hits
- miss_cnt  out  CNT_W  read misses

Behaviour:
- Reset (already decided): reset rst, asynchronous, active-high; clock clock. All valid bits, LRU bits and counters clear. State = IDLE. mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata = 0. ready = 1 while no request is present.
- Address decode: off = addr - BASE_ADDR, modulo 2^ADDR_W. word = off >> log2(DATA_W/8). index = low log2(SETS) bits of word. tag = remaining upper bits. Byte-offset bits are ignored.
- Arrays: per set, 2 ways of {valid, tag, data} plus 1 LRU bit. LRU = index of the least-recently-used way.
- Hit: valid and tag match in either way. A match in both ways cannot occur by construction.
- FSM states: IDLE, RD_MISS, WR_THRU.
- Requests: the requester holds rd_en/wr_en/addr/wdata stable while ready = 0. rd_en and wr_en together is treated as a write.
- IDLE, read hit:
  - rdata = hit-way data, combinational, same cycle. ready = 1.
  - At the clock edge: LRU points to the other way; hit_cnt increments.
- IDLE, read miss:
  - ready = 0 combinationally.
  - At the edge: go to RD_MISS, register mem_req = 1, mem_we = 0, mem_addr = off word-aligned; miss_cnt increments.
- RD_MISS:
  - mem_req is held until mem_ack.
  - In the ack cycle: rdata = mem_rdata, ready = 1.
  - At that edge: fill the victim way (way 0 if invalid, else way 1 if invalid, else the LRU way); set LRU to the other way; mem_req = 0; return to IDLE.
- IDLE, write:
  - ready = 0.
  - At the edge: if hit, update that way's data and LRU. No allocate on miss. Go to WR_THRU with mem_req = 1, mem_we = 1, mem_wdata = wdata.
- WR_THRU: ready = 1 in the ack cycle, then go to IDLE.
- Request timing: after any ack, the FSM is in IDLE for at least one cycle before a new request is issued, so back-to-back misses cost at least 2 + memory latency cycles.
- Flush:
  - Acted on only in IDLE: clears all valid and LRU bits at the edge.
  - If a request is present in the same cycle, flush takes priority. ready = 0 that cycle and the request is serviced next cycle as a miss.
  - flush asserted in RD_MISS/WR_THRU is held pending and applied on return to IDLE.
- Counters saturate at all-ones; they do not wrap.
- Reset mid-transaction: mem_req drops immediately. A late mem_ack arriving while in IDLE is ignored.
- mem_ack seen in IDLE is ignored.

Decomposition:
- Shared package (arm_pkg):
  - FSM state enum {IDLE, RD_MISS, WR_THRU}
  - function clog2
  - localparams INDEX_W, OFFSET_W, TAG_W derived from ADDR_W, DATA_W, SETS
- Sub-module cache_way_array: one way's valid/tag/data storage, with a synchronous write port and an asynchronous read port. Instantiate twice.
- FSM, LRU bits and counters live in the top.

Test Plan:
- Cold read, addr 0x400, mem returns 0xDEADBEEF after 3 cycles -> mem_addr = 0, ready low 4 cycles, rdata = 0xDEADBEEF on ack, miss_cnt = 1. Re-read -> same-cycle hit, ready stays 1, hit_cnt = 1.
- Conflict, SETS = 64: read 0x400, 0x500, 0x600 (all index 0) -> third fill evicts way holding 0x400 (LRU). Read 0x500 hits; read 0x400 misses.
- Write hit at 0x400 with 0x12345678 -> mem_we = 1, mem_wdata = 0x12345678, ready low until ack. Next read of 0x400 hits with 0x12345678. Write miss at 0x800 -> no allocate; next read of 0x800 misses.
- Flush after filling 3 lines -> every subsequent read misses. Flush asserted during RD_MISS -> applied after ack; the just-filled line is invalid.
- rst pulsed while in RD_MISS with mem_req = 1 -> mem_req = 0 at once, counters 0. A late mem_ack is ignored, state IDLE.
- CNT_W = 4: 20 read hits -> hit_cnt saturates at 15.
